// File: rtl/operand_triplet_loader_pkg.sv
// Shared definitions for the operand triplet loader and the comparator stage it feeds.
package operand_triplet_loader_pkg;

  // Default operand width, shared with the three-operand comparator stage
  localparam int OTL_WIDTH = 3;

  // Loader state encoding
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    LOAD_C = 2'd2,
    EVAL   = 2'd3
  } otl_state_t;

endpackage

// File: rtl/operand_triplet_loader_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module operand_triplet_loader_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear to zero, otherwise increment unless already all-ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/operand_triplet_loader.sv
// Assembles a serial operand stream into (a, b, c) triplets, presents each
// triplet to the comparator for one cycle and registers the 1-bit result.
module operand_triplet_loader
  import operand_triplet_loader_pkg::*;
#(
  parameter int WIDTH = OTL_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic             cmp_valid,
  input  logic             cmp_out,
  output logic             res_valid,
  output logic             res_bit,
  output logic [CNT_W-1:0] hit_count,
  output logic             busy
);

  otl_state_t       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             res_bit_q, res_bit_d;
  logic             res_valid_q, res_valid_d;
  logic             handshake;
  logic             hit_inc;

  assign handshake = in_valid & in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: clear always returns to LOAD_A, EVAL lasts one cycle
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = LOAD_A;
    end else begin
      case (state_q)
        LOAD_A:  if (handshake) state_d = LOAD_B;
        LOAD_B:  if (handshake) state_d = LOAD_C;
        LOAD_C:  if (handshake) state_d = EVAL;
        EVAL:    state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
  end

  // Output decode from state only; in_ready never depends on in_valid
  always_comb begin
    in_ready  = (state_q != EVAL);
    cmp_valid = (state_q == EVAL);
    busy      = (state_q != LOAD_A);
  end

  // Datapath next values: a/b/c are loaded together so the comparator
  // never sees a mixed triplet; a clear suppresses every update
  always_comb begin
    sa_d        = sa_q;
    sb_d        = sb_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    res_bit_d   = res_bit_q;
    res_valid_d = 1'b0;
    if (!clear) begin
      case (state_q)
        LOAD_A: if (handshake) sa_d = in_data;
        LOAD_B: if (handshake) sb_d = in_data;
        LOAD_C: begin
          if (handshake) begin
            a_d = sa_q;
            b_d = sb_q;
            c_d = in_data;
          end
        end
        EVAL: begin
          res_bit_d   = cmp_out;
          res_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q        <= '0;
      sb_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      res_bit_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      res_bit_q   <= res_bit_d;
      res_valid_q <= res_valid_d;
    end
  end

  // A hit is counted only for a completed evaluation that was not aborted
  assign hit_inc = (state_q == EVAL) && cmp_out && !clear;

  operand_triplet_loader_sat_counter #(
    .CNT_W(CNT_W)
  ) u_hit_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc),
    .clr   (clear),
    .count (hit_count)
  );

  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign res_bit   = res_bit_q;
  assign res_valid = res_valid_q;

endmodule

// File: tb/tb_operand_triplet_loader.sv
// Self-checking bench: triplets are pushed to a scoreboard as they are sent,
// and a negedge monitor compares evaluated triplets and results against it.
module tb_operand_triplet_loader;

  localparam int W  = 3;
  localparam int CW = 2;
  localparam logic [CW-1:0] HIT_MAX = '1;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         res;
  } trip_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic [W-1:0]  a, b, c;
  logic          cmp_valid;
  logic          cmp_out;
  logic          res_valid;
  logic          res_bit;
  logic [CW-1:0] hit_count;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  trip_t         exp_q[$];
  logic [CW-1:0] exp_hits = '0;
  logic [3*W-1:0] prev_abc = '0;
  logic          prev_cmp_valid = 1'b0;

  always #5 clk = ~clk;

  // Comparator stub: true when b > a
  assign cmp_out = (b > a);

  operand_triplet_loader #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .cmp_valid (cmp_valid),
    .cmp_out   (cmp_out),
    .res_valid (res_valid),
    .res_bit   (res_bit),
    .hit_count (hit_count),
    .busy      (busy)
  );

  // Monitor: evaluated triplets and results against the scoreboard
  always @(negedge clk) begin
    trip_t t;
    if (rst_n) begin
      if (cmp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL eval_unexpected a/b/c=%0d/%0d/%0d with no triplet sent", a, b, c);
        end else if ({a, b, c} !== {exp_q[0].a, exp_q[0].b, exp_q[0].c}) begin
          errors++;
          $display("FAIL eval_triplet got %0d/%0d/%0d expected %0d/%0d/%0d",
                   a, b, c, exp_q[0].a, exp_q[0].b, exp_q[0].c);
        end
        checks++;
        if (prev_cmp_valid) begin
          errors++;
          $display("FAIL cmp_valid_width got 2+ cycles expected 1");
        end
      end else if ({a, b, c} !== prev_abc) begin
        checks++;
        errors++;
        $display("FAIL abc_change got %0d/%0d/%0d outside evaluation, was %h", a, b, c, prev_abc);
      end
      if (res_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL res_unexpected res_valid=1 with no pending triplet");
        end else begin
          t = exp_q.pop_front();
          if (res_bit !== t.res) begin
            errors++;
            $display("FAIL res_bit for %0d/%0d/%0d got %0b expected %0b", t.a, t.b, t.c, res_bit, t.res);
          end
          if (t.res && exp_hits != HIT_MAX) exp_hits = exp_hits + 1'b1;
          checks++;
          if (hit_count !== exp_hits) begin
            errors++;
            $display("FAIL hit_count got %0d expected %0d", hit_count, exp_hits);
          end
          $display("result %0d/%0d/%0d -> res_bit=%0b hit_count=%0d", t.a, t.b, t.c, res_bit, hit_count);
        end
      end
    end
    prev_abc       = {a, b, c};
    prev_cmp_valid = cmp_valid & rst_n;
  end

  task automatic apply_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    exp_q.delete();
    exp_hits = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Offer one operand and wait (bounded) for its handshake edge
  task automatic send_op(input logic [W-1:0] v);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL handshake_timeout operand %0d got in_ready=0 expected 1 within 20 cycles", v);
    end
  endtask

  task automatic send_triplet(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z);
    trip_t t;
    send_op(x);
    send_op(y);
    send_op(z);
    t.a = x; t.b = y; t.c = z; t.res = (y > x);
    exp_q.push_back(t);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending results expected 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] sig;
    apply_reset();
    sig = {in_ready, busy, a, b, c, cmp_valid, res_valid, res_bit, hit_count};
    checks++;
    if (sig !== {1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_state got ready=%0b busy=%0b abc=%0d/%0d/%0d cv=%0b rv=%0b rb=%0b hc=%0d expected 1/0/0/0/0/0/0/0/0",
               in_ready, busy, a, b, c, cmp_valid, res_valid, res_bit, hit_count);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({in_ready, busy, a, b, c, cmp_valid, res_valid, res_bit, hit_count} !== sig[16:0]) begin
        errors++;
        $display("FAIL idle_hold cycle %0d outputs changed with in_valid=0", i);
      end
    end
    $display("reset/idle done");
  endtask

  task automatic test_single();
    trip_t t;
    apply_reset();
    send_op(3'd1);
    send_op(3'd7);
    checks++;
    if ({a, b, c} !== 9'd0) begin
      errors++;
      $display("FAIL single_early_abc got %0d/%0d/%0d expected 0/0/0", a, b, c);
    end
    send_op(3'd5);
    t.a = 3'd1; t.b = 3'd7; t.c = 3'd5; t.res = 1'b1;
    exp_q.push_back(t);
    in_valid = 1'b0;
    checks++;
    if ({a, b, c, cmp_valid} !== {3'd1, 3'd7, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL single_load got %0d/%0d/%0d cv=%0b expected 1/7/5 cv=1", a, b, c, cmp_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({res_valid, res_bit, hit_count, cmp_valid} !== {1'b1, 1'b1, 2'd1, 1'b0}) begin
      errors++;
      $display("FAIL single_result got rv=%0b rb=%0b hc=%0d cv=%0b expected 1/1/1/0",
               res_valid, res_bit, hit_count, cmp_valid);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_triplet(3'd2, 3'd1, 3'd5);
    send_triplet(3'd1, 3'd4, 3'd5);
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (hit_count !== 2'd1) begin
      errors++;
      $display("FAIL b2b_hits got %0d expected 1", hit_count);
    end
  endtask

  task automatic test_gapped();
    trip_t t;
    apply_reset();
    send_triplet(3'd6, 3'd2, 3'd0);
    in_valid = 1'b0;
    wait_drain();
    send_op(3'd3);
    send_op(3'd4);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({busy, in_ready, cmp_valid, a, b, c} !== {1'b1, 1'b1, 1'b0, 3'd6, 3'd2, 3'd0}) begin
        errors++;
        $display("FAIL gap_hold cycle %0d got busy=%0b rdy=%0b cv=%0b abc=%0d/%0d/%0d expected 1/1/0 6/2/0",
                 i, busy, in_ready, cmp_valid, a, b, c);
      end
    end
    send_op(3'd2);
    t.a = 3'd3; t.b = 3'd4; t.c = 3'd2; t.res = 1'b1;
    exp_q.push_back(t);
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_clear();
    trip_t t;
    apply_reset();
    send_triplet(3'd0, 3'd3, 3'd3);
    in_valid = 1'b0;
    wait_drain();
    send_op(3'd3);
    send_op(3'd5);
    // clear with an operand offered: it is consumed and dropped
    in_data = 3'd7;
    clear   = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    exp_hits = '0;
    checks++;
    if ({busy, in_ready, hit_count, res_valid} !== {1'b0, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL clear_state got busy=%0b rdy=%0b hc=%0d rv=%0b expected 0/1/0/0",
               busy, in_ready, hit_count, res_valid);
    end
    send_triplet(3'd1, 3'd5, 3'd1);
    in_valid = 1'b0;
    wait_drain();
    // clear during EVAL: no result, no increment
    send_triplet(3'd2, 3'd6, 3'd4);
    in_valid = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    void'(exp_q.pop_front());
    exp_hits = '0;
    checks++;
    if ({res_valid, hit_count, busy, a, b, c} !== {1'b0, 2'd0, 1'b0, 3'd2, 3'd6, 3'd4}) begin
      errors++;
      $display("FAIL clear_eval got rv=%0b hc=%0d busy=%0b abc=%0d/%0d/%0d expected 0/0/0 2/6/4",
               res_valid, hit_count, busy, a, b, c);
    end
    wait_drain();
  endtask

  task automatic test_saturation_and_reset();
    apply_reset();
    send_triplet(3'd0, 3'd1, 3'd0);
    send_triplet(3'd1, 3'd2, 3'd3);
    send_triplet(3'd2, 3'd7, 3'd0);
    send_triplet(3'd3, 3'd4, 3'd4);
    send_triplet(3'd5, 3'd6, 3'd1);
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (hit_count !== 2'd3) begin
      errors++;
      $display("FAIL saturation got %0d expected 3", hit_count);
    end
    // async reset in the middle of EVAL
    send_triplet(3'd1, 3'd2, 3'd3);
    in_valid = 1'b0;
    checks++;
    if (cmp_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_eval got cmp_valid=%0b expected 1", cmp_valid);
    end
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_hits = '0;
    #1;
    checks++;
    if ({in_ready, busy, a, b, c, cmp_valid, res_valid, res_bit, hit_count} !==
        {1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL async_reset got rdy=%0b busy=%0b abc=%0d/%0d/%0d cv=%0b rv=%0b rb=%0b hc=%0d expected 1/0/0/0/0/0/0/0/0",
               in_ready, busy, a, b, c, cmp_valid, res_valid, res_bit, hit_count);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_res got res_valid=%0b expected 0", res_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gapped();
    test_clear();
    test_saturation_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
